// File: rtl/multi_alu.sv
// Multi-function ALU: single-cycle ADD/AND/XOR/SUB, multi-cycle MUL.
// Results, error flag and completion pulse are all registered.
module multi_alu #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned CntW = 5;
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

    localparam logic [2:0] OpNop = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpXor = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpSub = 3'b101;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   mul_last;
    logic [2*WIDTH-1:0]     a_ext, b_ext, aq_ext, bq_ext;

    assign a_ext  = {{WIDTH{1'b0}}, A};
    assign b_ext  = {{WIDTH{1'b0}}, B};
    assign aq_ext = {{WIDTH{1'b0}}, a_q};
    assign bq_ext = {{WIDTH{1'b0}}, b_q};

    // A request is only seen while idle; NOP is never a request.
    assign accept   = start && (state_q == StIdle) && (op != OpNop);
    assign mul_last = (state_q == StMul) && (cnt_q == CntLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept && (op == OpMul) && (MUL_CYCLES > 1)) begin
                    state_d = StMul;
                end
            end
            StMul: begin
                if (mul_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;
        if (accept) begin
            a_d    = A;
            b_d    = B;
            done_d = 1'b1;
            case (op)
                OpAdd: begin
                    result_d = a_ext + b_ext;
                    err_d    = 1'b0;
                end
                OpAnd: begin
                    result_d = a_ext & b_ext;
                    err_d    = 1'b0;
                end
                OpXor: begin
                    result_d = a_ext ^ b_ext;
                    err_d    = 1'b0;
                end
                OpSub: begin
                    result_d = a_ext - b_ext;
                    err_d    = 1'b0;
                end
                OpMul: begin
                    if (MUL_CYCLES > 1) begin
                        // result/err stay put until the completing edge
                        done_d = 1'b0;
                        cnt_d  = CntW'(1);
                    end else begin
                        result_d = a_ext * b_ext;
                        err_d    = 1'b0;
                    end
                end
                default: begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
            endcase
        end else if (mul_last) begin
            result_d = aq_ext * bq_ext;
            err_d    = 1'b0;
            done_d   = 1'b1;
            cnt_d    = '0;
        end else if (state_q == StMul) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign done   = done_q;
    assign busy   = (state_q == StMul);
    assign err    = err_q;
    assign result = result_q;

endmodule
